window_mac_engine: RTL and testbench
====================================

Name: window_mac_engine

Overview:
- Responder side of the window start/done handshake used by the feature-map convolution controller.
- On start, snapshots a KSIZE x KSIZE signed 8-bit window and kernel, then computes the dot product with LANES multiply-accumulates per cycle.
- Pulses done for one cycle when the 32-bit result is valid.
- Port names and types allow drop-in replacement of the existing single-window engine under the controller.

Parameters:
- KSIZE, 5, kernel/window edge length; taps N_TAPS = KSIZE*KSIZE.
- LANES, 1, taps processed per cycle; must evenly divide N_TAPS (legal for KSIZE=5: 1, 5, 25). Illegal value -> elaboration error.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- weights  in  signed [7:0] [KSIZE-1:0][KSIZE-1:0]  kernel.
- inputs  in  signed [7:0] [KSIZE-1:0][KSIZE-1:0]  feature window.
- outputs  out  signed [31:0]  dot-product result, registered.
- done  out  1  one-cycle pulse: outputs holds a new valid result.
- busy  out  1  high in CALC and DONE; start is ignored while high.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, outputs=0, done=0, busy=0, accumulator=0, tap counter=0. Takes priority over every other event, including mid-operation: the current op aborts and no done is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=0: stay in IDLE.
  - start=1 at edge E0: copy inputs and weights into internal snapshot registers, clear accumulator, clear tap counter, go to CALC.
- CALC (N_TAPS/LANES cycles):
  - Each edge adds LANES products for taps t..t+LANES-1 to the accumulator. Taps are row-major: t = r*KSIZE + c.
  - Each edge advances t by LANES.
  - On the edge that consumes the last tap group, write the final sum to outputs and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. A start present in the DONE cycle is ignored.
- Latency: with start sampled at edge E0, done is high in the cycle following edge E(N_TAPS/LANES), with outputs valid in that same cycle.
  - LANES=1: done 25 cycles after the start edge. LANES=5: 5. LANES=25: 1.
  - Start held continuously high: one result every N_TAPS/LANES + 2 cycles.
- outputs changes only at op completion (or reset). It holds the last result through IDLE and through the next op's CALC.
- Snapshot semantics: changes on inputs/weights after E0 have no effect on the current op.
- Arithmetic:
  - Product = signed 8 x signed 8 -> signed 16, sign-extended to 32 before adding.
  - Accumulator is signed 32. Worst-case magnitude is 25*128*128 = 409600, so there is no overflow or saturation logic.
- done and busy are registered, decoded from state; no combinational path from start to any output.
- Handshake contract with the controller: the controller may hold start high until done is seen. Because start is ignored outside IDLE, exactly one op runs per request.

Test Plan:
- All inputs=1, all weights=1, LANES=1, start pulsed at E0 -> done high exactly in the cycle after E25, outputs=25, busy high from E1 through E26.
- All inputs=-128, weights=-128 -> outputs=409600. Inputs=-128, weights=127 -> outputs=-406400 (sign handling, no overflow).
- Identity kernel (weights[2][2]=1, others 0), inputs[2][2]=-7, others random -> outputs=-7. Randomize inputs and weights on every cycle after E0: result unchanged (snapshot).
- start held high for 100 cycles with LANES=1 -> done pulses every 27 cycles, each a single cycle wide, and outputs matches the reference dot product each time.
- Reset mid-op: assert rst at edge 10 of CALC -> next cycle outputs=0, busy=0, no done pulse. A fresh start then yields a correct result with full latency.
- LANES=5 and LANES=25 builds with random windows -> results identical to LANES=1, with done 5 and 1 cycles after the start edge respectively.

Source files
------------

// File: rtl/window_mac_engine.sv
// Window dot-product engine: snapshots a KSIZE x KSIZE signed 8-bit window and kernel on start,
// then accumulates LANES products per cycle and pulses done alongside the registered result.
module window_mac_engine #(
  parameter int KSIZE = 5,
  parameter int LANES = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic signed [KSIZE-1:0][KSIZE-1:0][7:0] weights,
  input  logic signed [KSIZE-1:0][KSIZE-1:0][7:0] inputs,
  output logic signed [31:0]                      outputs,
  output logic                                    done,
  output logic                                    busy
);

  localparam int N_TAPS   = KSIZE * KSIZE;
  localparam int N_GROUPS = (LANES > 0) ? N_TAPS / LANES : 1;
  localparam int GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int IW       = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  if (LANES < 1 || (N_TAPS % LANES) != 0) begin : g_bad_lanes
    $error("window_mac_engine: LANES must evenly divide KSIZE*KSIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            grp_q, grp_d;
  logic signed [31:0]       acc_q, acc_d;
  logic signed [31:0]       out_q, out_d;
  logic                     snap_en;
  // Flattened row-major snapshots: element r*KSIZE+c holds tap [r][c].
  logic [N_TAPS-1:0][7:0]   win_q, krn_q;

  logic [IW-1:0]            idx;
  logic signed [7:0]        a, b;
  logic signed [15:0]       prod;
  logic signed [31:0]       lane_sum;

  always_comb begin
    lane_sum = '0;
    idx      = '0;
    a        = '0;
    b        = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      idx      = IW'(int'(grp_q) * LANES + l);
      a        = win_q[idx];
      b        = krn_q[idx];
      prod     = 16'(a) * 16'(b);
      lane_sum = lane_sum + 32'(prod);
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    acc_d   = acc_q;
    out_d   = out_q;
    snap_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_en = 1'b1;
          acc_d   = '0;
          grp_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + lane_sum;
        if (grp_q == GW'(N_GROUPS - 1)) begin
          out_d   = acc_d;
          grp_d   = '0;
          state_d = DONE;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (snap_en) begin
      win_q <= inputs;
      krn_q <= weights;
    end
  end

  assign outputs = out_q;
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_window_mac_engine.sv
// Directed bench: three engine builds (LANES=1, 5, 25) share stimulus and are checked
// against a reference dot product for latency, result, pulse width and busy.
module tb_window_mac_engine;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [4:0][4:0][7:0] weights;
  logic signed [4:0][4:0][7:0] inputs;

  logic signed [31:0] o1, o5, o25;
  logic d1, d5, d25;
  logic b1, b5, b25;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  window_mac_engine #(.KSIZE(5), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .weights(weights), .inputs(inputs),
    .outputs(o1), .done(d1), .busy(b1));

  window_mac_engine #(.KSIZE(5), .LANES(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .weights(weights), .inputs(inputs),
    .outputs(o5), .done(d5), .busy(b5));

  window_mac_engine #(.KSIZE(5), .LANES(25)) u_dut25 (
    .clk(clk), .rst(rst), .start(start), .weights(weights), .inputs(inputs),
    .outputs(o25), .done(d25), .busy(b25));

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_dot();
    int s = 0;
    logic signed [7:0] x, w;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        x = inputs[r][c];
        w = weights[r][c];
        s += int'(x) * int'(w);
      end
    return s;
  endfunction

  task automatic fill(input int xv, input int wv);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        inputs[r][c]  = 8'(xv);
        weights[r][c] = 8'(wv);
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        inputs[r][c]  = 8'($urandom);
        weights[r][c] = 8'($urandom);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start at E0, watch 30 edges, then check all three builds.
  task automatic run_op(input string tag, input bit scramble);
    int exp;
    int lat1, lat5, lat25, cnt1, cnt5, cnt25, busy_err;
    logic signed [31:0] r1, r5, r25;
    exp  = ref_dot();
    lat1 = -1; lat5 = -1; lat25 = -1;
    cnt1 = 0;  cnt5 = 0;  cnt25 = 0; busy_err = 0;
    r1 = 'x; r5 = 'x; r25 = 'x;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (scramble) fill_rand();
      tick();
      if (d1)  begin cnt1++;  if (lat1 < 0)  begin lat1 = k;  r1 = o1;   end end
      if (d5)  begin cnt5++;  if (lat5 < 0)  begin lat5 = k;  r5 = o5;   end end
      if (d25) begin cnt25++; if (lat25 < 0) begin lat25 = k; r25 = o25; end end
      if (b1 !== (k <= 25)) busy_err++;
    end
    check({tag, "_lat1"}, lat1, 25);
    check({tag, "_lat5"}, lat5, 5);
    check({tag, "_lat25"}, lat25, 1);
    check({tag, "_res1"}, r1, exp);
    check({tag, "_res5"}, r5, exp);
    check({tag, "_res25"}, r25, exp);
    check({tag, "_width1"}, cnt1, 1);
    check({tag, "_width5"}, cnt5, 1);
    check({tag, "_width25"}, cnt25, 1);
    check({tag, "_busy1"}, busy_err, 0);
    check({tag, "_hold1"}, o1, exp);
  endtask

  initial begin
    int exp, last, pulses, width_err, no_done;
    bit prev;
    rst = 1'b1;
    start = 1'b0;
    fill(0, 0);
    tick();
    tick();
    check("rst_out1", o1, 0);
    check("rst_out25", o25, 0);
    check("rst_done1", 32'(d1), 0);
    check("rst_busy1", 32'(b1), 0);
    check("rst_busy5", 32'(b5), 0);
    rst = 1'b0;
    tick();

    fill(1, 1);
    run_op("ones", 1'b0);
    check("ones_const", o1, 25);

    fill(-128, -128);
    run_op("neg_neg", 1'b0);
    check("neg_neg_const", o1, 409600);

    fill(-128, 127);
    run_op("neg_pos", 1'b0);
    check("neg_pos_const", o5, -406400);

    fill_rand();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) weights[r][c] = 8'd0;
    weights[2][2] = 8'd1;
    inputs[2][2]  = -8'sd7;
    run_op("ident", 1'b1);
    check("ident_const", o25, -7);

    for (int n = 0; n < 3; n++) begin
      fill_rand();
      run_op($sformatf("rand%0d", n), 1'b1);
    end

    // Start held high: one result every 27 cycles on the LANES=1 build.
    fill_rand();
    exp = ref_dot();
    last = -1; pulses = 0; width_err = 0; prev = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (d1) begin
        if (prev) width_err++;
        else begin
          pulses++;
          if (last < 0) check("hold_first", i, 25);
          else check("hold_gap", i - last, 27);
          check("hold_val", o1, exp);
          last = i;
        end
      end
      prev = d1;
    end
    start = 1'b0;
    check("hold_pulses", pulses, 3);
    check("hold_width", width_err, 0);
    repeat (30) tick();

    // Abort at the 10th CALC edge of the LANES=1 build.
    fill_rand();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_abort_busy", 32'(b1), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out", o1, 0);
    check("abort_busy", 32'(b1), 0);
    check("abort_done", 32'(d1), 0);
    no_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (d1) no_done++;
    end
    check("abort_no_done", no_done, 0);
    check("abort_out_held", o1, 0);

    fill_rand();
    run_op("after_abort", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
